// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the 5-stage MIPS core control logic.
//   - state_t  : sequencer state encodings (RUN / DRAIN / HALTED)
//   - ZERO_REG : architectural $zero, which never creates a dependency
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_t;

    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage : mips_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating event counter. It stops at all-ones and never wraps.
//   Ports:
//     i_clock  clock
//     i_reset  synchronous active-high reset, clears the count
//     i_valid  global enable; the count holds while low
//     i_inc    count this cycle (qualified by i_valid)
//     o_count  current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int NB_COUNT = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_inc,
    output logic [NB_COUNT-1:0] o_count
);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values no matter how the blocks are ordered.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_count <= '0;
        end else if (i_valid && i_inc && (o_count != '1)) begin
            o_count <= o_count + NB_COUNT'(1);
        end
    end

endmodule : sat_counter

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//   Pipeline sequencer for the 5-stage MIPS core. It works beside the
//   forwarding unit.
//   - Stalls (holds PC and IF/ID, bubbles ID/EX) on hazards that forwarding
//     cannot cover: load-use, and branch/jr operands still in flight.
//   - Flushes IF/ID on a taken control transfer that is not stalled.
//   - On HALT it drains EX/MEM/WB for N_DRAIN cycles, then parks in HALTED.
//   - Saturating stall and flush counters are provided for the debug unit.
//   Ports:
//     i_clock, i_reset          clock, synchronous active-high reset
//     i_valid                   global enable; low freezes all state
//     i_rs_id/i_rt_id, i_use_*  source operands of the ID instruction
//     i_branch_id, i_jump_rs_id control instruction resolved in ID
//     i_taken_id, i_halt_id     taken control transfer / HALT in ID
//     i_we_ex, i_load_ex, i_rd_ex   EX-stage destination info
//     i_load_mem, i_rd_mem          MEM-stage destination info
//     o_hold_pc, o_hold_if_id, o_bubble_ex, o_flush_if_id   pipeline control
//     o_halted                  pipeline drained and stopped
//     o_stall_count, o_flush_count  saturating performance counters
// -----------------------------------------------------------------------------
module hazard_control_unit
    import mips_pkg::*;
#(
    parameter int NB_REG_ADDR = 5,
    parameter int NB_COUNT    = 16,
    parameter int N_DRAIN     = 3
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic [NB_REG_ADDR-1:0] i_rs_id,
    input  logic [NB_REG_ADDR-1:0] i_rt_id,
    input  logic                   i_use_rs_id,
    input  logic                   i_use_rt_id,
    input  logic                   i_branch_id,
    input  logic                   i_jump_rs_id,
    input  logic                   i_taken_id,
    input  logic                   i_halt_id,
    input  logic                   i_we_ex,
    input  logic                   i_load_ex,
    input  logic [NB_REG_ADDR-1:0] i_rd_ex,
    input  logic                   i_load_mem,
    input  logic [NB_REG_ADDR-1:0] i_rd_mem,
    output logic                   o_hold_pc,
    output logic                   o_hold_if_id,
    output logic                   o_bubble_ex,
    output logic                   o_flush_if_id,
    output logic                   o_halted,
    output logic [NB_COUNT-1:0]    o_stall_count,
    output logic [NB_COUNT-1:0]    o_flush_count
);

    localparam int NB_DRAIN = (N_DRAIN > 1) ? $clog2(N_DRAIN) : 1;
    localparam logic [NB_REG_ADDR-1:0] ZERO_ADDR = NB_REG_ADDR'(ZERO_REG);

    state_t              state, next_state, cur_state;
    logic [NB_DRAIN-1:0] drain_cnt, next_drain_cnt;

    // ---------------- hazard detection ----------------
    logic rd_ex_nz, rd_mem_nz;
    logic ctl_rs, ctl_rt;
    logic ex_hits_ops, ex_hits_ctl, mem_hits_ctl;
    logic lu, cx, cl2, cm, stall_now;

    assign rd_ex_nz  = (i_rd_ex  != ZERO_ADDR);
    assign rd_mem_nz = (i_rd_mem != ZERO_ADDR);

    // Operands that a branch/jr consumes in ID. These cannot be forwarded from EX/MEM.
    assign ctl_rs = i_branch_id | i_jump_rs_id;
    assign ctl_rt = i_branch_id;

    assign ex_hits_ops  = rd_ex_nz & ((i_use_rs_id & (i_rs_id == i_rd_ex)) |
                                      (i_use_rt_id & (i_rt_id == i_rd_ex)));
    assign ex_hits_ctl  = rd_ex_nz & ((ctl_rs & (i_rs_id == i_rd_ex)) |
                                      (ctl_rt & (i_rt_id == i_rd_ex)));
    assign mem_hits_ctl = rd_mem_nz & ((ctl_rs & (i_rs_id == i_rd_mem)) |
                                       (ctl_rt & (i_rt_id == i_rd_mem)));

    assign lu  = i_load_ex & ex_hits_ops;
    assign cx  = i_we_ex & ~i_load_ex & ex_hits_ctl;
    // A load feeding a branch needs two stalls. The second stall comes from cm,
    // because the load moves into MEM while ID is held.
    assign cl2 = i_load_ex & ex_hits_ctl;
    assign cm  = i_load_mem & mem_hits_ctl;
    assign stall_now = lu | cx | cl2 | cm;

    // Outputs reflect RUN during the reset cycle itself, even when the
    // register still holds DRAIN or HALTED.
    assign cur_state = i_reset ? RUN : state;

    // ---------------- sequencer ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else if (i_valid) begin
            state     <= next_state;
            drain_cnt <= next_drain_cnt;
        end
    end

    logic hold, flush, stall_inc;

    always_comb begin
        // NOTE: every output of this block gets a default first. Then no path
        // leaves a variable unassigned, and no latch is inferred.
        next_state     = state;
        next_drain_cnt = drain_cnt;
        hold           = 1'b0;
        flush          = 1'b0;
        stall_inc      = 1'b0;
        o_halted       = 1'b0;

        case (cur_state)
            RUN: begin
                hold      = stall_now;
                stall_inc = stall_now;
                // A stall dominates: a taken branch or HALT stays in ID and
                // is evaluated again next cycle.
                flush     = i_taken_id & ~stall_now;
                if (i_halt_id && !stall_now) begin
                    next_state     = DRAIN;
                    next_drain_cnt = NB_DRAIN'(N_DRAIN - 1);
                end
            end
            DRAIN: begin
                hold = 1'b1;
                if (drain_cnt == '0) begin
                    next_state = HALTED;
                end else begin
                    next_drain_cnt = drain_cnt - NB_DRAIN'(1);
                end
            end
            HALTED: begin
                hold     = 1'b1;
                o_halted = 1'b1;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    assign o_hold_pc     = hold;
    assign o_hold_if_id  = hold;
    assign o_bubble_ex   = hold;
    assign o_flush_if_id = flush;

    // ---------------- performance counters ----------------
    sat_counter #(.NB_COUNT(NB_COUNT)) u_stall_counter (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_inc   (stall_inc),
        .o_count (o_stall_count)
    );

    sat_counter #(.NB_COUNT(NB_COUNT)) u_flush_counter (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_inc   (flush),
        .o_count (o_flush_count)
    );

endmodule : hazard_control_unit

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencer for the 5-stage MIPS core, sitting beside the forwarding unit.
- Detects hazards that forwarding cannot cover (load-use; branch/jump-register operands still in flight) and holds PC and IF/ID while bubbling ID/EX.
- Flushes IF/ID on taken control transfers.
- Drains the pipeline on a decoded HALT, then parks in HALTED. Exposes saturating stall/flush counters to the debug unit.

Parameters:
- NB_REG_ADDR, 5, register address width
- NB_COUNT, 16, width of the stall and flush performance counters
- N_DRAIN, 3, cycles to drain EX/MEM/WB after HALT leaves ID

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  global pipeline enable from the debug unit; low freezes all state
- i_rs_id  in  NB_REG_ADDR  rs of instruction in ID
- i_rt_id  in  NB_REG_ADDR  rt of instruction in ID
- i_use_rs_id  in  1  ID instruction reads rs
- i_use_rt_id  in  1  ID instruction reads rt
- i_branch_id  in  1  ID holds beq/bne; compares rs and rt in ID
- i_jump_rs_id  in  1  ID holds jr/jalr; reads rs in ID
- i_taken_id  in  1  ID control transfer resolved taken
- i_halt_id  in  1  ID holds HALT
- i_we_ex  in  1  EX instruction writes a register
- i_load_ex  in  1  EX instruction is a load
- i_rd_ex  in  NB_REG_ADDR  EX destination register
- i_load_mem  in  1  MEM instruction is a load
- i_rd_mem  in  NB_REG_ADDR  MEM destination register
- o_hold_pc  out  1  PC keeps its value
- o_hold_if_id  out  1  IF/ID register keeps its value
- o_bubble_ex  out  1  ID/EX loads a NOP (all control bits zero)
- o_flush_if_id  out  1  IF/ID loads a NOP
- o_halted  out  1  pipeline fully drained and stopped
- o_stall_count  out  NB_COUNT  cycles with o_hold_pc=1 while in RUN
- o_flush_count  out  NB_COUNT  cycles with o_flush_if_id=1

Behaviour:
- Address 0 never matches; every compare is qualified by a nonzero address.
- Hazard terms, evaluated combinationally in RUN:
  - lu = i_load_ex & rd_ex matches (i_use_rs_id & rs) or (i_use_rt_id & rt).
  - Control operand set: rs if (i_branch_id | i_jump_rs_id); rt if i_branch_id.
  - cx = i_we_ex & ~i_load_ex & rd_ex in the control operand set.
  - cl2 = i_load_ex & rd_ex in the control operand set.
  - cm = i_load_mem & rd_mem in the control operand set.
  - stall_now = lu | cx | cl2 | cm.
- Stall semantics:
  - o_hold_pc = o_hold_if_id = o_bubble_ex = stall_now.
  - cl2 needs two stall cycles. The second cycle is covered by cm next cycle, since the load advances while ID is held. No extra counter is used.
- Flush: o_flush_if_id = i_taken_id & ~stall_now & state==RUN. Asserted in the same cycle.
- FSM states: RUN, DRAIN, HALTED. The state register updates only when i_valid=1.
  - RUN -> DRAIN on i_halt_id & ~stall_now. A stalled HALT waits in ID. drain_cnt <= N_DRAIN-1.
  - DRAIN: o_hold_pc = o_hold_if_id = o_bubble_ex = 1; o_flush_if_id = 0. drain_cnt decrements each valid cycle. At drain_cnt==0 go to HALTED.
  - HALTED: all holds and the bubble are 1; o_halted=1. Exit only by reset.
- Counters:
  - o_stall_count increments on i_valid & state==RUN & stall_now.
  - o_flush_count increments on i_valid & o_flush_if_id.
  - Both saturate at all-ones with no wrap.
- i_valid=0: FSM, drain_cnt and counters hold. Outputs are still driven combinationally from current state and inputs. The downstream pipeline registers ignore them because they are gated by i_valid too.
- Reset, including mid-DRAIN or HALTED: state=RUN, drain_cnt=0, counters=0, o_halted=0. Combinational outputs reflect RUN in the same cycle.
- Simultaneous events:
  - stall_now dominates i_taken_id and i_halt_id; the control instruction re-evaluates next cycle.
  - lu and a control hazard together produce a single stall per cycle, counted once.

Decomposition:
- Shared package (mips_pkg): FSM state encodings (RUN=2'b00, DRAIN=2'b01, HALTED=2'b10) and the ZERO_REG address constant.
- One sub-module: sat_counter (parameter NB_COUNT; ports i_clock, i_reset, i_valid, i_inc, o_count), instantiated twice.

Test Plan:
- Load-use: lw $3 in EX, add reading $3 in ID, i_valid=1 -> one cycle of hold_pc/hold_if_id/bubble_ex; next cycle (load in MEM, not cm because ID is not a branch) no stall; o_stall_count=1.
- Branch after load: beq $4,$0 in ID, lw $4 in EX -> stall cycle 1 (cl2); next cycle lw $4 in MEM -> stall cycle 2 (cm); third cycle no stall; o_stall_count=2.
- Register $0: lw $0 in EX, ID reads $0 -> no stall; jr $5 with ALU rd=5 in EX -> exactly one stall.
- Taken vs stall: i_taken_id=1 with cx=1 -> flush=0 and stall=1; next cycle cx=0, taken=1 -> flush=1, o_flush_count=1.
- Halt drain with gaps: i_halt_id in RUN, i_valid toggled 1,0,1,1 -> DRAIN lasts 3 valid cycles, then o_halted=1 with all holds=1; a stalled HALT does not enter DRAIN.
- Reset and saturation: reset asserted in HALTED -> next cycle state RUN, o_halted=0, counters 0; NB_COUNT=2 with 5 stalls -> o_stall_count=3.
